// File: rtl/mem_bus_master.sv
// Initiator for the data-memory bus: one request in flight, fixed-latency reads, one-cycle response pulse.
// Optional write read-back check is enabled by defining MEM_BUS_MASTER_VERIFY_EN.
module mem_bus_master #(
   parameter int unsigned READ_LATENCY = 1,
   parameter logic [15:0] ADDR_LIMIT   = 16'h2002
`ifdef MEM_BUS_MASTER_VERIFY_EN
   ,
   parameter logic [15:0] RAM_TOP      = 16'h2000
`endif
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        rsp_err,
   output logic [15:0] mem_address,
   output logic        mem_load,
   output logic [15:0] mem_in,
   input  logic [15:0] mem_out
);

   localparam logic [2:0] LAT = READ_LATENCY[2:0];

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ,
      RESP
`ifdef MEM_BUS_MASTER_VERIFY_EN
      ,
      VERIFY
`endif
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [2:0]  cnt_q, cnt_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= 16'h0000;
         wdata_q <= 16'h0000;
         rdata_q <= 16'h0000;
         err_q   <= 1'b0;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               rdata_d = 16'h0000;
               cnt_d   = LAT;
               // Illegal requests never touch the bus, so the address register keeps its old value.
               if (req_addr >= ADDR_LIMIT) begin
                  err_d   = 1'b1;
                  state_d = RESP;
               end else begin
                  err_d  = 1'b0;
                  addr_d = req_addr;
                  if (req_write) begin
                     wdata_d = req_wdata;
                     state_d = WRITE;
                  end else begin
                     state_d = READ;
                  end
               end
            end
         end
         WRITE: begin
`ifdef MEM_BUS_MASTER_VERIFY_EN
            if (addr_q < RAM_TOP) begin
               cnt_d   = LAT;
               state_d = VERIFY;
            end else begin
               state_d = RESP;
            end
`else
            state_d = RESP;
`endif
         end
         READ: begin
            if (cnt_q == 3'd0) begin
               rdata_d = mem_out;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
`ifdef MEM_BUS_MASTER_VERIFY_EN
         VERIFY: begin
            if (cnt_q == 3'd0) begin
               rdata_d = mem_out;
               err_d   = (mem_out != wdata_q);
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
`endif
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Everything below decodes registered state, so async reset clears it without a clock.
   assign req_ready   = (state_q == IDLE) && !reset;
   assign mem_load    = (state_q == WRITE);
   assign mem_address = addr_q;
   assign mem_in      = wdata_q;
   assign rsp_valid   = (state_q == RESP);
   assign rsp_rdata   = rdata_q;
   assign rsp_err     = err_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master with a latency-1 memory model (RAM, LED register, button).
module tb_mem_bus_master;

   localparam int L = 1;
`ifdef MEM_BUS_MASTER_VERIFY_EN
   localparam int WR_RAM_CYC = L + 3;
`else
   localparam int WR_RAM_CYC = 2;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [15:0] req_addr = 16'h0000;
   logic [15:0] req_wdata = 16'h0000;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        rsp_err;
   logic [15:0] mem_address;
   logic        mem_load;
   logic [15:0] mem_in;
   logic [15:0] mem_out = 16'h0000;

   int total = 0;
   int bad = 0;

   logic [15:0] ram [0:8191];
   logic        led = 1'b0;
   logic        btn = 1'b0;
   logic        corrupt = 1'b0;

   always #5 clk = ~clk;

   mem_bus_master #(.READ_LATENCY(L), .ADDR_LIMIT(16'h2002)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_address(mem_address), .mem_load(mem_load), .mem_in(mem_in),
      .mem_out(mem_out)
   );

   function automatic logic [15:0] mem_rd(input logic [15:0] a);
      if (a < 16'h2000) return ram[a[12:0]];
      if (a == 16'h2000) return {15'b0, led};
      if (a == 16'h2001) return {15'b0, btn};
      return 16'h0000;
   endfunction

   // Memory block: one-cycle read latency, write on clock with load high.
   always @(posedge clk) begin
      if (mem_load) begin
         if (mem_address < 16'h2000)
            ram[mem_address[12:0]] <= corrupt ? (mem_in ^ 16'h0001) : mem_in;
         else if (mem_address == 16'h2000)
            led <= mem_in[0];
      end
      mem_out <= mem_rd(mem_address);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issues one request from IDLE; returns the response cycle (0 on timeout) and bus activity.
   task automatic txn(input logic w, input logic [15:0] a, input logic [15:0] d,
                      output int cyc, output int loads, output logic [15:0] rdata,
                      output logic err, output logic [15:0] la, output logic [15:0] ld);
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0;
      cyc = 0; loads = 0; rdata = 16'hxxxx; err = 1'bx; la = 16'hxxxx; ld = 16'hxxxx;
      for (int c = 1; c <= 20; c++) begin
         if (mem_load) begin loads++; la = mem_address; ld = mem_in; end
         if (rsp_valid) begin cyc = c; rdata = rsp_rdata; err = rsp_err; break; end
         @(negedge clk);
      end
      @(negedge clk);
   endtask

   initial begin
      int cyc, loads, rsps, first_rdy;
      logic [15:0] rd, la, ld;
      logic er;
      logic hold;
      for (int i = 0; i < 8192; i++) ram[i] = 16'h0000;

      // Reset state
      @(negedge clk); @(negedge clk);
      chk("rst_ready", req_ready, 1'b0);
      chk("rst_load", mem_load, 1'b0);
      chk("rst_addr", mem_address, 16'h0000);
      chk("rst_in", mem_in, 16'h0000);
      chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 18'h0);
      reset = 1'b0;
      #1 chk("rel_ready", req_ready, 1'b1);
      @(negedge clk);

      // 1: write 0x0000 <- -1
      txn(1'b1, 16'h0000, 16'hFFFF, cyc, loads, rd, er, la, ld);
      chk("w0_cyc", cyc, WR_RAM_CYC);
      chk("w0_loads", loads, 1);
      chk("w0_la", la, 16'h0000);
      chk("w0_ld", ld, 16'hFFFF);
      chk("w0_err", er, 1'b0);
      chk("w0_ready_after", {req_ready, rsp_valid}, 2'b10);

      // 2: read it back
      txn(1'b0, 16'h0000, 16'h0000, cyc, loads, rd, er, la, ld);
      chk("r0_cyc", cyc, L + 2);
      chk("r0_loads", loads, 0);
      chk("r0_data", rd, 16'hFFFF);
      chk("r0_err", er, 1'b0);

      // 3: IO registers
      txn(1'b1, 16'h2000, 16'h0001, cyc, loads, rd, er, la, ld);
      chk("led_cyc", cyc, 2);
      chk("led_on", led, 1'b1);
      chk("led_rdata", rd, 16'h0000);
      btn = 1'b1;
      txn(1'b0, 16'h2001, 16'h0000, cyc, loads, rd, er, la, ld);
      chk("btn_rd", rd, 16'h0001);
      txn(1'b1, 16'h2000, 16'h0002, cyc, loads, rd, er, la, ld);
      chk("led_off", led, 1'b0);
      txn(1'b1, 16'h2000, 16'd12345, cyc, loads, rd, er, la, ld);
      chk("led_12345", led, 1'b1);

      // 4: illegal addresses
      txn(1'b0, 16'h6000, 16'h0000, cyc, loads, rd, er, la, ld);
      chk("ill_cyc", cyc, 1);
      chk("ill_err", er, 1'b1);
      chk("ill_rdata", rd, 16'h0000);
      chk("ill_loads", loads, 0);
      chk("ill_addr_held", mem_address, 16'h2000);
      txn(1'b1, 16'hFFFF, 16'h1234, cyc, loads, rd, er, la, ld);
      chk("illw_err_loads", {er, 8'(loads)}, {1'b1, 8'd0});
      chk("illw_cyc", cyc, 1);

      // 5: back-to-back writes with req_valid held
      req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0001; req_wdata = 16'd9999;
      @(posedge clk); @(negedge clk);
      req_addr = 16'h0002; req_wdata = 16'h0001;
      loads = 0; rsps = 0; first_rdy = 0; hold = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         if (mem_load) loads++;
         if (rsp_valid) rsps++;
         if (hold && req_ready) begin
            first_rdy = c;
            @(posedge clk); @(negedge clk);
            req_valid = 1'b0; hold = 1'b0;
         end else begin
            @(negedge clk);
         end
      end
      chk("b2b_first_ready", first_rdy, WR_RAM_CYC + 1);
      chk("b2b_loads", loads, 2);
      chk("b2b_rsps", rsps, 2);
      chk("b2b_ram1", ram[1], 16'd9999);
      chk("b2b_ram2", ram[2], 16'h0001);

      // 6: reset during WRITE
      req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0003; req_wdata = 16'h00AA;
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0;
      chk("mid_load_pre", mem_load, 1'b1);
      #1 reset = 1'b1;
      #1;
      chk("mid_load", mem_load, 1'b0);
      chk("mid_addr_in", {mem_address, mem_in}, 32'h0);
      chk("mid_rsp", {rsp_valid, rsp_err, rsp_rdata}, 18'h0);
      chk("mid_ready", req_ready, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      #1 chk("mid_rel_ready", req_ready, 1'b1);
      rsps = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (rsp_valid) rsps++;
      end
      chk("mid_no_rsp", rsps, 0);
      chk("mid_no_write", ram[3], 16'h0000);

`ifdef MEM_BUS_MASTER_VERIFY_EN
      corrupt = 1'b1;
      txn(1'b1, 16'h0004, 16'h1234, cyc, loads, rd, er, la, ld);
      corrupt = 1'b0;
      chk("vfy_bad_cyc", cyc, L + 3);
      chk("vfy_bad_err", er, 1'b1);
      chk("vfy_bad_rd", rd, 16'h1235);
      txn(1'b1, 16'h0005, 16'h55AA, cyc, loads, rd, er, la, ld);
      chk("vfy_ok_err", er, 1'b0);
      chk("vfy_ok_rd", rd, 16'h55AA);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
